exp2_seq: RTL and testbench
===========================

EXP2_SEQ -- requirements
Module: exp2_seq

Interface
REQ-001 The block SHALL have parameter OUT_W, default 8, giving the one-hot output width; it must be a power of two and at least 2.
REQ-002 The block SHALL have localparam IN_W, equal to $clog2(OUT_W) (3 at default), giving the exponent width.
REQ-003 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port in_valid, input, 1 bit: exponent on in is offered.
REQ-006 Port in_ready, output, 1 bit: block can accept an exponent.
REQ-007 Port in, input, IN_W bits: exponent k, in range 0..OUT_W-1.
REQ-008 Port out_valid, output, 1 bit: result on out is valid.
REQ-009 Port out_ready, input, 1 bit: consumer takes the result.
REQ-010 Port out, output, OUT_W bits: one-hot result, 1 << k.
REQ-011 Port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT and HOLD, with all state registered.
REQ-013 in_ready SHALL be high exactly when state == IDLE; there is no registered bypass.
REQ-014 Acceptance SHALL occur on an edge where in_valid && in_ready: cnt <= in, shreg <= 1; next state is HOLD if in == 0, else SHIFT.
REQ-015 In SHIFT, each edge SHALL perform shreg <= shreg << 1 and cnt <= cnt - 1; when cnt == 1, the next state is HOLD.
REQ-016 Latency: with acceptance in cycle 0, out_valid SHALL first be high in cycle k+1 (1 cycle for k=0, 8 cycles for k=7 at default).
REQ-017 In HOLD, out_valid SHALL be 1 and out SHALL equal shreg, which is exactly one bit set at position k.
REQ-018 out and out_valid SHALL hold stable while out_valid && !out_ready (backpressure of any length).
REQ-019 On an HOLD edge with out_ready high, the next state SHALL be IDLE and out_valid SHALL be 0 in the following cycle.
REQ-020 Back-to-back operation: the earliest next acceptance SHALL be the cycle after the HOLD->IDLE transition, giving a minimum period of k+2 cycles.
REQ-021 out SHALL be all-zero whenever out_valid is 0.
REQ-022 in_valid asserted in SHIFT or HOLD SHALL be ignored and SHALL leave no state change.
REQ-023 out_ready asserted in IDLE or SHIFT SHALL have no effect.
REQ-024 shreg SHALL never shift past bit OUT_W-1; cnt never underflows, because SHIFT is left at cnt == 1.
REQ-025 For every accepted k, the result SHALL satisfy $clog2(out) == k, the inverse of the one-hot-to-log encoder.

Reset
REQ-026 rst_n low SHALL immediately, without waiting for clk, force state = IDLE, cnt = 0, shreg = 0, out = 0, out_valid = 0 and busy = 0.
REQ-027 While rst_n is low, in_ready SHALL be 1 (the state is IDLE), but no acceptance occurs.
REQ-028 Reset during SHIFT or HOLD SHALL discard the transaction; no out_valid may appear for it after reset release.
REQ-029 The first acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-030 Package exp2_pkg SHALL hold the state typedef (enum IDLE/SHIFT/HOLD) and the default OUT_W constant.
REQ-031 The block SHALL be a single module with no sub-modules; the FSM, cnt and shreg are inline.

Verification
REQ-032 After reset, accept in=2 with out_ready=1 -> out_valid high in cycle 3, out = 8'b0000_0100, busy low after the handshake.
REQ-033 Accept in=0 -> out = 8'b0000_0001 in cycle 1; accept in=7 -> out = 8'b1000_0000 in cycle 8.
REQ-034 Accept in=4 with out_ready held low for 5 cycles -> out = 8'b0001_0000 stable throughout, released on the out_ready edge.
REQ-035 Drive in_valid continuously with in=6 then 3 during SHIFT -> in=3 is ignored until IDLE, and the first result is 8'b0100_0000.
REQ-036 Assert rst_n low mid-SHIFT for in=5 -> outputs zero immediately, no result after release, and the next in=1 gives 8'b0000_0010.
REQ-037 Sweep k = 0..7 with random out_ready -> every result satisfies $clog2(out) == k and each result is one-hot.

Source files
------------

// File: rtl/exp2_pkg.sv
// rtl/exp2_pkg.sv - shared state encoding and default width for exp2_seq
package exp2_pkg;

  localparam int EXP2_OUT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } exp2_state_t;

endpackage

// File: rtl/exp2_seq.sv
// rtl/exp2_seq.sv - sequential 2^k encoder: shifts a single 1 left k times and holds the one-hot result
module exp2_seq
  import exp2_pkg::*;
#(
  parameter  int OUT_W = EXP2_OUT_W,
  localparam int IN_W  = $clog2(OUT_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out,
  output logic             busy
);

  exp2_state_t      r_state;
  exp2_state_t      w_next;
  logic [IN_W-1:0]  r_cnt;
  logic [OUT_W-1:0] r_shreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next = (in == '0) ? HOLD : SHIFT;
      SHIFT:   if (r_cnt == IN_W'(1)) w_next = HOLD;
      HOLD:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // SHIFT is left at cnt == 1, so the single 1 stops exactly at bit k
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_shreg <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_cnt   <= in;
            r_shreg <= OUT_W'(1);
          end
        end
        SHIFT: begin
          r_cnt   <= r_cnt - IN_W'(1);
          r_shreg <= r_shreg << 1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == HOLD);
  assign busy      = (r_state != IDLE);
  assign out       = out_valid ? r_shreg : '0;

endmodule

// File: tb/tb_exp2_seq.sv
// tb/tb_exp2_seq.sv - directed self-checking bench for exp2_seq
module tb_exp2_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_k;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_w;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  exp2_seq #(.OUT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in_k),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out_w),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept k, measure latency, check the result, then drain it with fixed or random out_ready
  task automatic run_k(input int k, input bit rnd);
    int         lat;
    bit         done;
    logic [7:0] exp_out;
    logic [7:0] held;
    exp_out   = 8'd1 << k;
    out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    chk("idle_ready", in_ready, 1);
    in_k      = k[2:0];
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    lat       = 1;
    while (!out_valid && lat < 20) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      tick();
      lat++;
    end
    chk($sformatf("latency_k%0d", k), lat, k + 1);
    chk($sformatf("out_k%0d", k), out_w, exp_out);
    chk($sformatf("onehot_k%0d", k), $onehot(out_w), 1);
    chk($sformatf("clog2_k%0d", k), $clog2(out_w), k);
    held = out_w;
    done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      else     out_ready = 1'b1;
      done = out_ready;
      tick();
      if (!done) chk("hold_stable", {out_valid, out_w}, {1'b1, held});
    end
    chk($sformatf("released_k%0d", k), {out_valid, busy, out_w}, 0);
  endtask

  initial begin
    int vcount;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_k      = 3'd2;
    out_ready = 1'b1;
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", out_w, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    tick();
    tick();
    chk("rst_no_accept", {busy, out_valid}, 0);

    // Release away from the edge with in=2 already offered: accepted on the first edge
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("k2_c1_busy", {busy, in_ready, out_valid}, 3'b100);
    tick();
    chk("k2_c2_valid", out_valid, 0);
    tick();
    chk("k2_c3_valid", out_valid, 1);
    chk("k2_c3_out", out_w, 8'b0000_0100);
    tick();
    chk("k2_c4_done", {out_valid, busy, in_ready, out_w}, 11'b001_0000_0000);

    run_k(0, 1'b0);
    run_k(7, 1'b0);

    // Backpressure: result must stay put for 5 cycles of out_ready low
    out_ready = 1'b0;
    in_k      = 3'd4;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    repeat (4) tick();
    chk("bp_first_valid", {out_valid, out_w}, {1'b1, 8'b0001_0000});
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_stable", {out_valid, out_w}, {1'b1, 8'b0001_0000});
    end
    out_ready = 1'b1;
    tick();
    chk("bp_release", {out_valid, busy, out_w}, 0);

    // in_valid held through SHIFT/HOLD with a changing exponent
    out_ready = 1'b1;
    in_k      = 3'd6;
    in_valid  = 1'b1;
    tick();
    in_k      = 3'd3;
    vcount    = 1;
    while (!out_valid && vcount < 20) begin
      tick();
      vcount++;
    end
    chk("busy_in_lat", vcount, 7);
    chk("busy_in_out", out_w, 8'b0100_0000);
    tick();
    chk("busy_in_idle", {in_ready, out_valid}, 2'b10);
    tick();
    in_valid = 1'b0;
    vcount   = 1;
    while (!out_valid && vcount < 20) begin
      tick();
      vcount++;
    end
    chk("second_lat", vcount, 4);
    chk("second_out", out_w, 8'b0000_1000);
    tick();

    // Reset mid-SHIFT discards the transaction
    in_k     = 3'd5;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("pre_rst_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", {out_valid, busy, in_ready, out_w}, 11'b001_0000_0000);
    tick();
    @(negedge clk);
    rst_n  = 1'b1;
    vcount = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid || busy) vcount++;
    end
    chk("no_ghost_result", vcount, 0);
    run_k(1, 1'b0);

    for (int k = 0; k < 8; k++) run_k(k, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
